// File: rtl/data_in_packer.sv
// data_in_packer
//  Packs a 32-bit host word stream into 382-bit tagged packets for the shared
//  broadcast bus feeding every core's input FIFO controller. Packet layout is
//  {payload[375:0], id[5:0]}, assembled little-endian (word 0 carries the ID).
//  A completed packet is held in a pending register while any core FIFO is
//  almost full, so no controller ever drops a broadcast. Emitted packets are
//  counted and done is raised once the programmed total has gone out.
//
// Ports
//  clk            in   1      clock, rising edge
//  rst            in   1      synchronous, active-high reset
//  start          in   1      enable; low freezes all state
//  total_pkts     in   CNT_W  packets to emit before done
//  in_valid       in   1      host word valid
//  in_data        in   32     host word
//  in_ready       out  1      combinational; word taken when in_valid & in_ready
//  any_almostfull in   1      OR of all core FIFO almost-full flags
//  data_in_valid  out  1      one-cycle broadcast strobe (registered)
//  data_in        out  382    broadcast packet, holds last emitted value
//  pkt_count      out  CNT_W  packets emitted since reset, saturating
//  done           out  1      sticky once pkt_count reaches total_pkts

module data_in_packer #(
    parameter int unsigned WORDS_PER_PKT = 12,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] total_pkts,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    input  logic             any_almostfull,
    output logic             data_in_valid,
    output logic [381:0]     data_in,
    output logic [CNT_W-1:0] pkt_count,
    output logic             done
);

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned PKT_W    = 382;
    localparam int unsigned LAST_IDX = WORDS_PER_PKT - 1;
    localparam int unsigned ASM_W    = WORD_W * LAST_IDX;
    localparam int unsigned LAST_W   = PKT_W - ASM_W;
    localparam int unsigned IDX_W    = $clog2(WORDS_PER_PKT);

    logic [IDX_W-1:0] idx;
    logic [ASM_W-1:0] asm_buf;
    logic [PKT_W-1:0] pend_pkt;
    logic             pending;

    logic             last_word;
    logic             count_reached;
    logic             emit_now;
    logic             accept;
    logic [CNT_W-1:0] cnt_next;

    // Handshake and emit decisions.
    // Words 0..10 of the next packet may still be taken while a packet is
    // pending; only the closing word must wait for the pending slot to free.
    // count_reached keeps in_ready low in the cycle before done registers,
    // which matters when total_pkts is zero.
    always_comb begin
        last_word     = (idx == IDX_W'(LAST_IDX));
        count_reached = (pkt_count == total_pkts);
        emit_now      = start & ~done & pending & ~any_almostfull;
        in_ready      = ~rst & start & ~done & ~count_reached
                        & ~(pending & last_word & ~emit_now);
        accept        = in_valid & in_ready;
        cnt_next      = pkt_count;
        if (emit_now && (pkt_count != {CNT_W{1'b1}})) begin
            cnt_next = pkt_count + CNT_W'(1);
        end
    end

    // Word assembly, pending slot, broadcast register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= '0;
            asm_buf       <= '0;
            pend_pkt      <= '0;
            pending       <= 1'b0;
            data_in_valid <= 1'b0;
            data_in       <= '0;
            pkt_count     <= '0;
            done          <= 1'b0;
        end else begin
            data_in_valid <= 1'b0;

            if (accept) begin
                if (last_word) begin
                    // Top two bits of the closing word fall off the 382-bit packet.
                    pend_pkt <= {in_data[LAST_W-1:0], asm_buf};
                    idx      <= '0;
                end else begin
                    for (int unsigned k = 0; k < LAST_IDX; k++) begin
                        if (idx == IDX_W'(k)) begin
                            asm_buf[k*WORD_W +: WORD_W] <= in_data;
                        end
                    end
                    idx <= idx + IDX_W'(1);
                end
            end

            // A reload in the emit cycle keeps the slot occupied.
            if (accept && last_word) begin
                pending <= 1'b1;
            end else if (emit_now) begin
                pending <= 1'b0;
            end

            if (emit_now) begin
                data_in       <= pend_pkt;
                data_in_valid <= 1'b1;
            end

            pkt_count <= cnt_next;

            if (start && (cnt_next == total_pkts)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_in_packer.sv
// Directed bench for data_in_packer: reset values, single packet, back-to-back
// stream, almost-full backpressure, start pause, mid-packet reset, zero total.
module tb_data_in_packer;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned PKT_W = 382;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] total_pkts = '0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_data = '0;
    logic             in_ready;
    logic             any_almostfull = 1'b0;
    logic             data_in_valid;
    logic [PKT_W-1:0] data_in;
    logic [CNT_W-1:0] pkt_count;
    logic             done;

    data_in_packer #(.WORDS_PER_PKT(12), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .total_pkts     (total_pkts),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .any_almostfull (any_almostfull),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .pkt_count      (pkt_count),
        .done           (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle.
    logic [PKT_W-1:0] strobe_pkt[$];
    int               strobe_cyc[$];
    always @(negedge clk) begin
        if (data_in_valid === 1'b1) begin
            strobe_pkt.push_back(data_in);
            strobe_cyc.push_back(cyc);
        end
    end

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wbuf [12];

    function automatic logic [PKT_W-1:0] exp_pkt();
        return {wbuf[11][29:0], wbuf[10], wbuf[9], wbuf[8], wbuf[7], wbuf[6],
                wbuf[5], wbuf[4], wbuf[3], wbuf[2], wbuf[1], wbuf[0]};
    endfunction

    task automatic fill_wbuf(input logic [5:0] id, input logic [31:0] seed);
        wbuf[0] = {seed[31:6], id};
        for (int k = 1; k < 12; k++) wbuf[k] = seed + 32'(k) * 32'h1111_1111;
    endtask

    // All tasks start and end at a falling edge.
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; any_almostfull = 1'b0;
        repeat (2) @(negedge clk);
        strobe_pkt.delete();
        strobe_cyc.delete();
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, output int acc_cyc);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) begin
            vectors++; miscompares++;
            $display("FAIL send_word timeout: in_ready=%b required 1", in_ready);
        end
        acc_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic send_words(input int lo, input int hi, output int acc_last);
        int c;
        c = 0;
        for (int k = lo; k <= hi; k++) send_word(wbuf[k], c);
        acc_last = c;
    endtask

    task automatic wait_strobes(input int n, input int budget);
        int k;
        k = 0;
        while (strobe_pkt.size() < n && k < budget) begin
            @(negedge clk); k++;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (strobe_pkt.size() != n) begin
            miscompares++;
            $display("FAIL strobe_count: got %0d required %0d", strobe_pkt.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; total_pkts = 32'd5; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset in_ready: got %b required 0", in_ready); end
        vectors++; if (data_in_valid !== 1'b0) begin miscompares++; $display("FAIL reset data_in_valid: got %b required 0", data_in_valid); end
        vectors++; if (data_in !== '0) begin miscompares++; $display("FAIL reset data_in: got %h required 0", data_in); end
        vectors++; if (pkt_count !== '0) begin miscompares++; $display("FAIL reset pkt_count: got %0d required 0", pkt_count); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b required 0", done); end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_one_pkt();
        int acc;
        logic [PKT_W-1:0] exp;
        do_reset();
        total_pkts = 32'd1; start = 1'b1;
        wbuf[0] = 32'h0000_0005;
        for (int k = 1; k <= 10; k++) wbuf[k] = 32'(k);
        wbuf[11] = 32'hFFFF_FFFF;
        exp = exp_pkt();
        send_words(0, 11, acc);
        in_valid = 1'b0;
        wait_strobes(1, 30);
        if (strobe_pkt.size() >= 1) begin
            vectors++; if (strobe_pkt[0][5:0] !== 6'd5) begin miscompares++; $display("FAIL one_pkt id: got %0d required 5", strobe_pkt[0][5:0]); end
            vectors++; if (strobe_pkt[0][381:352] !== 30'h3FFF_FFFF) begin miscompares++; $display("FAIL one_pkt top: got %h required 3fffffff", strobe_pkt[0][381:352]); end
            vectors++; if (strobe_pkt[0] !== exp) begin miscompares++; $display("FAIL one_pkt data: got %h required %h", strobe_pkt[0], exp); end
            vectors++; if (strobe_cyc[0] - acc !== 2) begin miscompares++; $display("FAIL one_pkt latency: got %0d required 2", strobe_cyc[0] - acc); end
        end
        vectors++; if (pkt_count !== 32'd1) begin miscompares++; $display("FAIL one_pkt pkt_count: got %0d required 1", pkt_count); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL one_pkt done: got %b required 1", done); end
        in_valid = 1'b1; in_data = 32'h0000_0007;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL one_pkt ready_after_done: got %b required 0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc;
        logic [PKT_W-1:0] exp [4];
        do_reset();
        total_pkts = 32'd4; start = 1'b1;
        for (int p = 0; p < 4; p++) begin
            fill_wbuf(6'(p), 32'hA5C3_0000 + 32'(p) * 32'h0101_0100);
            exp[p] = exp_pkt();
            send_words(0, 11, acc);
        end
        in_valid = 1'b0;
        wait_strobes(4, 40);
        for (int p = 0; p < 4; p++) begin
            if (strobe_pkt.size() > p) begin
                vectors++; if (strobe_pkt[p][5:0] !== 6'(p)) begin miscompares++; $display("FAIL b2b id[%0d]: got %0d required %0d", p, strobe_pkt[p][5:0], p); end
                vectors++; if (strobe_pkt[p] !== exp[p]) begin miscompares++; $display("FAIL b2b data[%0d]: got %h required %h", p, strobe_pkt[p], exp[p]); end
                if (p > 0) begin
                    vectors++; if (strobe_cyc[p] - strobe_cyc[p-1] !== 12) begin miscompares++; $display("FAIL b2b spacing[%0d]: got %0d required 12", p, strobe_cyc[p] - strobe_cyc[p-1]); end
                end
            end
        end
        vectors++; if (pkt_count !== 32'd4) begin miscompares++; $display("FAIL b2b pkt_count: got %0d required 4", pkt_count); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b done: got %b required 1", done); end
    endtask

    task automatic test_backpressure();
        int acc;
        logic [PKT_W-1:0] exp1, exp2;
        do_reset();
        total_pkts = 32'd2; start = 1'b1;
        fill_wbuf(6'd10, 32'h1234_5678);
        exp1 = exp_pkt();
        send_words(0, 10, acc);
        any_almostfull = 1'b1;
        send_word(wbuf[11], acc);
        fill_wbuf(6'd11, 32'h9ABC_DEF0);
        exp2 = exp_pkt();
        send_words(0, 10, acc);
        in_valid = 1'b1; in_data = wbuf[11];
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp ready_hold[%0d]: got %b required 0", i, in_ready); end
            @(negedge clk);
        end
        vectors++; if (strobe_pkt.size() != 0) begin miscompares++; $display("FAIL bp no_strobe: got %0d required 0", strobe_pkt.size()); end
        any_almostfull = 1'b0;
        send_word(wbuf[11], acc);
        in_valid = 1'b0;
        wait_strobes(2, 20);
        if (strobe_pkt.size() >= 2) begin
            vectors++; if (strobe_pkt[0] !== exp1) begin miscompares++; $display("FAIL bp pkt1: got %h required %h", strobe_pkt[0], exp1); end
            vectors++; if (strobe_pkt[1] !== exp2) begin miscompares++; $display("FAIL bp pkt2: got %h required %h", strobe_pkt[1], exp2); end
            vectors++; if (strobe_cyc[1] - strobe_cyc[0] !== 1) begin miscompares++; $display("FAIL bp spacing: got %0d required 1", strobe_cyc[1] - strobe_cyc[0]); end
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL bp done: got %b required 1", done); end
    endtask

    task automatic test_start_pause();
        int acc;
        logic [PKT_W-1:0] exp;
        do_reset();
        total_pkts = 32'd1; start = 1'b1;
        fill_wbuf(6'd20, 32'h0F0F_3C3C);
        exp = exp_pkt();
        send_words(0, 5, acc);
        start = 1'b0; in_valid = 1'b1; in_data = wbuf[6];
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL pause ready[%0d]: got %b required 0", i, in_ready); end
            @(negedge clk);
        end
        start = 1'b1;
        send_words(6, 11, acc);
        in_valid = 1'b0;
        wait_strobes(1, 20);
        if (strobe_pkt.size() >= 1) begin
            vectors++; if (strobe_pkt[0] !== exp) begin miscompares++; $display("FAIL pause data: got %h required %h", strobe_pkt[0], exp); end
        end
    endtask

    task automatic test_rst_mid();
        int acc;
        logic [PKT_W-1:0] exp;
        do_reset();
        total_pkts = 32'd3; start = 1'b1;
        fill_wbuf(6'd30, 32'hCAFE_0000);
        send_words(0, 11, acc);
        in_valid = 1'b0;
        wait_strobes(1, 20);
        vectors++; if (pkt_count !== 32'd1) begin miscompares++; $display("FAIL rst_mid pre_count: got %0d required 1", pkt_count); end
        fill_wbuf(6'd31, 32'hBEEF_0000);
        send_words(0, 6, acc);
        in_valid = 1'b1; in_data = wbuf[7]; rst = 1'b1;
        @(negedge clk);
        #1;
        vectors++; if (data_in !== '0) begin miscompares++; $display("FAIL rst_mid data_in: got %h required 0", data_in); end
        vectors++; if (data_in_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid valid: got %b required 0", data_in_valid); end
        vectors++; if (pkt_count !== '0) begin miscompares++; $display("FAIL rst_mid pkt_count: got %0d required 0", pkt_count); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_mid done: got %b required 0", done); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mid in_ready: got %b required 0", in_ready); end
        rst = 1'b0; in_valid = 1'b0; total_pkts = 32'd1;
        strobe_pkt.delete();
        strobe_cyc.delete();
        @(negedge clk);
        fill_wbuf(6'd32, 32'h7654_3210);
        exp = exp_pkt();
        send_words(0, 11, acc);
        in_valid = 1'b0;
        wait_strobes(1, 20);
        if (strobe_pkt.size() >= 1) begin
            vectors++; if (strobe_pkt[0][5:0] !== 6'd32) begin miscompares++; $display("FAIL rst_mid fresh_id: got %0d required 32", strobe_pkt[0][5:0]); end
            vectors++; if (strobe_pkt[0] !== exp) begin miscompares++; $display("FAIL rst_mid fresh_data: got %h required %h", strobe_pkt[0], exp); end
        end
    endtask

    task automatic test_zero_total();
        do_reset();
        total_pkts = '0; in_valid = 1'b1; in_data = 32'h0000_0001; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL zero ready[%0d]: got %b required 0", i, in_ready); end
            vectors++; if (done !== (i > 0)) begin miscompares++; $display("FAIL zero done[%0d]: got %b required %b", i, done, (i > 0)); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++; if (strobe_pkt.size() != 0) begin miscompares++; $display("FAIL zero strobes: got %0d required 0", strobe_pkt.size()); end
        vectors++; if (pkt_count !== '0) begin miscompares++; $display("FAIL zero pkt_count: got %0d required 0", pkt_count); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_one_pkt();
        test_back_to_back();
        test_backpressure();
        test_start_pause();
        test_rst_mid();
        test_zero_total();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
